// File: rtl/ajuste_hora_alarma.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ajuste_hora_alarma_rep
//   Push-button step generator with hold-to-repeat. A press gives one step in
//   the cycle the button rises. Holding it gives another step REPEAT_DELAY
//   cycles after the press, then one step every REPEAT_RATE cycles. Releasing
//   the button clears the count at once.
//
//   A button that is already held when reset is released is locked out. It
//   must be seen low once before a press is accepted again.
//
// Ports
//   clk     in  system clock, rising edge
//   reset   in  asynchronous, active-high reset
//   i_btn   in  conditioned button level, active-high
//   o_rise  out button rising edge, used to silence the alarm
//   o_step  out one-cycle increment request (edge or auto-repeat)
// -----------------------------------------------------------------------------
module ajuste_hora_alarma_rep #(
    parameter int unsigned REPEAT_DELAY = 32'd50000000,
    parameter int unsigned REPEAT_RATE  = 32'd10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise,
    output logic o_step
);

    // ST_LOCK : after reset, waiting to see the button low
    // ST_IDLE : button released, waiting for a press
    // ST_DELAY: held, counting towards the first repeat
    // ST_REPEAT: held, counting between repeats
    typedef enum logic [1:0] {
        ST_LOCK,
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_t;

    rep_state_t  r_state;
    rep_state_t  w_state_nxt;
    logic        r_prev;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_cnt_inc;

    // The counter holds at all-ones rather than wrapping back to zero.
    assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

    // NOTE: clocked state uses non-blocking assignments so that every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOCK;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= i_btn;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt holds the number of cycles since the press (or since the last
    // repeat), so a step is due when it reaches the programmed interval.
    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        o_rise      = 1'b0;
        o_step      = 1'b0;
        case (r_state)
            ST_LOCK: begin
                if (!i_btn) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_btn && !r_prev) begin
                    o_rise      = 1'b1;
                    o_step      = 1'b1;
                    w_cnt_nxt   = 32'd1;
                    w_state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!i_btn) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == REPEAT_DELAY) begin
                    o_step      = 1'b1;
                    w_cnt_nxt   = 32'd1;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (!i_btn) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == REPEAT_RATE) begin
                    o_step    = 1'b1;
                    w_cnt_nxt = 32'd1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_LOCK;
            end
        endcase
    end

endmodule

// -----------------------------------------------------------------------------
// ajuste_hora_alarma
//   Editing block for the digital clock. It stores the alarm time and lets the
//   user set either the alarm (modo 2) or the running time (modo 1) with the
//   hour and minute buttons. It also rings the alarm when the time matches.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   modo    [1:0] in   0/3 normal, 1 set time, 2 set alarm
//   btnHora       in   hour button (debounced level)
//   btnMin        in   minute button (debounced level)
//   alarmaEn      in   alarm enable switch
//   minutos [6:0] in   current minute from the time counter
//   horas   [4:0] in   current hour from the time counter
//   minutosAl     out  stored alarm minute
//   horasAl       out  stored alarm hour
//   cargaHora     out  one-cycle load request for the time counter
//   minutosCarga  out  minute value to load
//   horasCarga    out  hour value to load
//   alarma        out  alarm ringing (level)
// -----------------------------------------------------------------------------
module ajuste_hora_alarma #(
    parameter int unsigned REPEAT_DELAY = 32'd50000000,
    parameter int unsigned REPEAT_RATE  = 32'd10000000,
    parameter int unsigned ALARM_RST_H  = 32'd6,
    parameter int unsigned ALARM_RST_M  = 32'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] modo,
    input  logic       btnHora,
    input  logic       btnMin,
    input  logic       alarmaEn,
    input  logic [6:0] minutos,
    input  logic [4:0] horas,
    output logic [6:0] minutosAl,
    output logic [4:0] horasAl,
    output logic       cargaHora,
    output logic [6:0] minutosCarga,
    output logic [4:0] horasCarga,
    output logic       alarma
);

    localparam logic [1:0] MODO_SET_TIME  = 2'd1;
    localparam logic [1:0] MODO_SET_ALARM = 2'd2;

    // Increment with wrap. Any out-of-range value also goes to 0.
    function automatic logic [6:0] f_inc_min(input logic [6:0] v);
        return (v >= 7'd59) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [4:0] f_inc_hora(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    logic       w_rise_min;
    logic       w_step_min;
    logic       w_rise_hora;
    logic       w_step_hora;
    logic       w_set_time;
    logic       w_set_alarm;
    logic       w_match;
    logic       w_alarm_set;
    logic       w_alarm_clr;

    logic [6:0] r_min_al;
    logic [4:0] r_hora_al;
    logic       r_carga;
    logic [6:0] r_min_carga;
    logic [4:0] r_hora_carga;
    logic       r_match;
    logic       r_alarma;

    ajuste_hora_alarma_rep #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep_min (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btnMin),
        .o_rise (w_rise_min),
        .o_step (w_step_min)
    );

    ajuste_hora_alarma_rep #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep_hora (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btnHora),
        .o_rise (w_rise_hora),
        .o_step (w_step_hora)
    );

    assign w_set_time  = (modo == MODO_SET_TIME);
    assign w_set_alarm = (modo == MODO_SET_ALARM);

    // The match is blocked while the user edits the running time, so the
    // time being edited cannot ring the alarm.
    assign w_match = alarmaEn && !w_set_time
                  && (minutos == r_min_al) && (horas == r_hora_al);

    assign w_alarm_set = w_match && !r_match;
    assign w_alarm_clr = w_rise_min || w_rise_hora || !alarmaEn
                      || (r_match && !w_match);

    // Alarm time: minutes and hours wrap independently, with no carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_min_al  <= 7'(ALARM_RST_M);
            r_hora_al <= 5'(ALARM_RST_H);
        end else if (w_set_alarm) begin
            if (w_step_min) begin
                r_min_al <= f_inc_min(r_min_al);
            end
            if (w_step_hora) begin
                r_hora_al <= f_inc_hora(r_hora_al);
            end
        end
    end

    // Time load. In set-time mode the shadow copy tracks the live time, so
    // the next step increments from what the user is looking at. A load
    // always carries both fields, stepped or not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carga      <= 1'b0;
            r_min_carga  <= '0;
            r_hora_carga <= '0;
        end else begin
            r_carga <= w_set_time && (w_step_min || w_step_hora);
            if (w_set_time) begin
                r_min_carga  <= w_step_min  ? f_inc_min(minutos)  : minutos;
                r_hora_carga <= w_step_hora ? f_inc_hora(horas)   : horas;
            end
        end
    end

    // Alarm level. Clear takes priority over set in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_match  <= 1'b0;
            r_alarma <= 1'b0;
        end else begin
            r_match <= w_match;
            if (w_alarm_clr) begin
                r_alarma <= 1'b0;
            end else if (w_alarm_set) begin
                r_alarma <= 1'b1;
            end
        end
    end

    assign minutosAl    = r_min_al;
    assign horasAl      = r_hora_al;
    assign cargaHora    = r_carga;
    assign minutosCarga = r_min_carga;
    assign horasCarga   = r_hora_carga;
    assign alarma       = r_alarma;

endmodule
